// File: rtl/wb_pipe.sv
// rtl/wb_pipe.sv - writeback stage: source select, memory-wait hold, register/flag commit, retire count
module wb_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int N_FLAGS  = 4,
    parameter int CNT_W    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic               CLK,
    input  logic               rf_RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               wb_flush,
    input  logic [DATA_W-1:0]  mxpc_out,
    input  logic [DATA_W-1:0]  dm_Q,
    input  logic               dm_valid,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  imm,
    input  logic [1:0]         uc_S_MXRB,
    input  logic               uc_W_RD,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [N_FLAGS-1:0] alu_flags,
    input  logic [N_FLAGS-1:0] uc_W_RF,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [N_FLAGS-1:0] rf_flags,
    output logic [CNT_W-1:0]   retire_cnt
);

    typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_h_we;
    logic [ADDR_W-1:0]  r_h_addr;
    logic [N_FLAGS-1:0] r_h_flags;
    logic [N_FLAGS-1:0] r_h_mask;

    logic               w_accept;
    logic               w_src_ready;
    logic               w_commit;
    logic               w_hold;
    logic               w_c_we;
    logic [ADDR_W-1:0]  w_c_addr;
    logic [DATA_W-1:0]  w_c_data;
    logic [N_FLAGS-1:0] w_c_flags;
    logic [N_FLAGS-1:0] w_c_mask;
    logic [DATA_W-1:0]  w_sel_data;

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid && in_ready && !wb_flush;
    assign w_src_ready = (uc_S_MXRB != 2'b01) || dm_valid;
    assign w_hold      = w_accept && !w_src_ready;

    always_comb begin
        w_sel_data = alu_result;
        case (uc_S_MXRB)
            2'b00:   w_sel_data = alu_result;
            2'b01:   w_sel_data = dm_Q;
            2'b10:   w_sel_data = mxpc_out;
            default: w_sel_data = imm;
        endcase
    end

    // Commit fields come from the live inputs in IDLE and from the holding registers in WAIT_MEM.
    always_comb begin
        w_commit  = 1'b0;
        w_c_we    = uc_W_RD;
        w_c_addr  = rd_addr;
        w_c_data  = w_sel_data;
        w_c_flags = alu_flags;
        w_c_mask  = uc_W_RF;
        if (r_state == IDLE) begin
            w_commit = w_accept && w_src_ready;
        end else begin
            w_commit  = dm_valid && !wb_flush;
            w_c_we    = r_h_we;
            w_c_addr  = r_h_addr;
            w_c_data  = dm_Q;
            w_c_flags = r_h_flags;
            w_c_mask  = r_h_mask;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_hold) w_next_state = WAIT_MEM;
            WAIT_MEM: if (wb_flush || dm_valid) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rf_RESET) begin
        if (!rf_RESET) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_ff @(posedge CLK or negedge rf_RESET) begin
        if (!rf_RESET) begin
            r_h_we    <= 1'b0;
            r_h_addr  <= '0;
            r_h_flags <= '0;
            r_h_mask  <= '0;
        end else if (w_hold) begin
            r_h_we    <= uc_W_RD;
            r_h_addr  <= rd_addr;
            r_h_flags <= alu_flags;
            r_h_mask  <= uc_W_RF;
        end
    end

    always_ff @(posedge CLK or negedge rf_RESET) begin
        if (!rf_RESET) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_flags   <= '0;
            retire_cnt <= '0;
        end else if (w_commit) begin
            // Register 0 writes are dropped but still retire.
            rf_we      <= w_c_we && !((ZERO_REG != 0) && (w_c_addr == '0));
            rf_waddr   <= w_c_addr;
            rf_wdata   <= w_c_data;
            rf_flags   <= (rf_flags & ~w_c_mask) | (w_c_flags & w_c_mask);
            retire_cnt <= retire_cnt + 1'b1;
        end else begin
            rf_we      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_pipe.sv
// tb/tb_wb_pipe.sv - directed self-checking bench for wb_pipe
module tb_wb_pipe;

    logic        CLK = 1'b0;
    logic        rf_RESET;
    logic        in_valid;
    logic        in_ready;
    logic        wb_flush;
    logic [31:0] mxpc_out;
    logic [31:0] dm_Q;
    logic        dm_valid;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [1:0]  uc_S_MXRB;
    logic        uc_W_RD;
    logic [3:0]  rd_addr;
    logic [3:0]  alu_flags;
    logic [3:0]  uc_W_RF;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_flags;
    logic [3:0]  retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    wb_pipe #(.DATA_W(32), .ADDR_W(4), .N_FLAGS(4), .CNT_W(4), .ZERO_REG(1)) dut (
        .CLK(CLK), .rf_RESET(rf_RESET), .in_valid(in_valid), .in_ready(in_ready),
        .wb_flush(wb_flush), .mxpc_out(mxpc_out), .dm_Q(dm_Q), .dm_valid(dm_valid),
        .alu_result(alu_result), .imm(imm), .uc_S_MXRB(uc_S_MXRB), .uc_W_RD(uc_W_RD),
        .rd_addr(rd_addr), .alu_flags(alu_flags), .uc_W_RF(uc_W_RF), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_flags(rf_flags), .retire_cnt(retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [1:0] sel, input logic [3:0] rd, input logic wrd,
                        input logic [3:0] fl, input logic [3:0] msk);
        in_valid  = 1'b1;
        uc_S_MXRB = sel;
        rd_addr   = rd;
        uc_W_RD   = wrd;
        alu_flags = fl;
        uc_W_RF   = msk;
    endtask

    initial begin
        rf_RESET = 1'b0; in_valid = 1'b0; wb_flush = 1'b0; mxpc_out = 32'h100;
        dm_Q = 32'h0; dm_valid = 1'b0; alu_result = 32'h0; imm = 32'h0;
        uc_S_MXRB = 2'b00; uc_W_RD = 1'b0; rd_addr = 4'd0; alu_flags = 4'h0; uc_W_RF = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_we", {31'b0, rf_we}, 32'd0);
        check("reset_wdata", rf_wdata, 32'd0);
        check("reset_cnt", {28'b0, retire_cnt}, 32'd0);
        check("reset_ready", {31'b0, in_ready}, 32'd1);
        #3 rf_RESET = 1'b1;

        // Plain ALU writeback
        alu_result = 32'h0000_00A5;
        beat(2'b00, 4'd3, 1'b1, 4'h0, 4'h0);
        tick();
        check("alu_we", {31'b0, rf_we}, 32'd1);
        check("alu_waddr", {28'b0, rf_waddr}, 32'd3);
        check("alu_wdata", rf_wdata, 32'hA5);
        check("alu_cnt", {28'b0, retire_cnt}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("alu_we_drop", {31'b0, rf_we}, 32'd0);
        check("alu_wdata_hold", rf_wdata, 32'hA5);

        // Flag masking, back-to-back
        imm = 32'h11;
        beat(2'b11, 4'd5, 1'b1, 4'hF, 4'h5);
        tick();
        check("mask1_flags", {28'b0, rf_flags}, 32'h5);
        check("mask1_wdata", rf_wdata, 32'h11);
        imm = 32'h22;
        beat(2'b11, 4'd6, 1'b1, 4'h0, 4'h1);
        tick();
        check("mask2_flags", {28'b0, rf_flags}, 32'h4);
        check("mask2_we", {31'b0, rf_we}, 32'd1);
        check("mask2_cnt", {28'b0, retire_cnt}, 32'd3);
        in_valid = 1'b0;

        // PC-link source
        mxpc_out = 32'h0000_0104;
        beat(2'b10, 4'd14, 1'b1, 4'h0, 4'h0);
        tick();
        check("pc_wdata", rf_wdata, 32'h104);
        check("pc_cnt", {28'b0, retire_cnt}, 32'd4);

        // Memory wait: held fields must survive changes on the inputs
        beat(2'b01, 4'd7, 1'b1, 4'h8, 4'h8);
        dm_valid = 1'b0;
        tick();
        check("wait_ready0", {31'b0, in_ready}, 32'd0);
        check("wait_we0", {31'b0, rf_we}, 32'd0);
        in_valid = 1'b0; rd_addr = 4'd9; uc_W_RF = 4'h0; alu_flags = 4'h0;
        tick();
        check("wait_ready1", {31'b0, in_ready}, 32'd0);
        tick();
        check("wait_ready2", {31'b0, in_ready}, 32'd0);
        check("wait_cnt", {28'b0, retire_cnt}, 32'd4);
        dm_valid = 1'b1; dm_Q = 32'hDEAD_BEEF;
        tick();
        check("mem_we", {31'b0, rf_we}, 32'd1);
        check("mem_waddr", {28'b0, rf_waddr}, 32'd7);
        check("mem_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("mem_flags", {28'b0, rf_flags}, 32'hC);
        check("mem_cnt", {28'b0, retire_cnt}, 32'd5);
        check("mem_ready", {31'b0, in_ready}, 32'd1);
        dm_valid = 1'b0;
        tick();
        check("mem_single_pulse", {31'b0, rf_we}, 32'd0);

        // Flush beats a simultaneous dm_valid in WAIT_MEM
        beat(2'b01, 4'd8, 1'b1, 4'hF, 4'hF);
        tick();
        check("fl_ready0", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0; wb_flush = 1'b1; dm_valid = 1'b1; dm_Q = 32'h1111_2222;
        tick();
        check("fl_we", {31'b0, rf_we}, 32'd0);
        check("fl_cnt", {28'b0, retire_cnt}, 32'd5);
        check("fl_ready", {31'b0, in_ready}, 32'd1);
        check("fl_flags", {28'b0, rf_flags}, 32'hC);
        dm_valid = 1'b0;

        // Flush in IDLE drops the offered beat
        alu_result = 32'h55;
        beat(2'b00, 4'd2, 1'b1, 4'h0, 4'h0);
        tick();
        check("fli_we", {31'b0, rf_we}, 32'd0);
        check("fli_wdata", rf_wdata, 32'hDEAD_BEEF);
        wb_flush = 1'b0;

        // Register 0 suppression and no-write commit both retire
        alu_result = 32'h77;
        beat(2'b00, 4'd0, 1'b1, 4'h0, 4'h0);
        tick();
        check("zr_we", {31'b0, rf_we}, 32'd0);
        check("zr_cnt", {28'b0, retire_cnt}, 32'd6);
        beat(2'b00, 4'd4, 1'b0, 4'h0, 4'h0);
        tick();
        check("nowr_we", {31'b0, rf_we}, 32'd0);
        check("nowr_cnt", {28'b0, retire_cnt}, 32'd7);

        // Wrap the 4-bit counter with consecutive writes
        for (int i = 0; i < 9; i++) begin
            alu_result = 32'h200 + i;
            beat(2'b00, 4'd1, 1'b1, 4'h0, 4'h0);
            tick();
            check("wrap_we", {31'b0, rf_we}, 32'd1);
            check("wrap_cnt", {28'b0, retire_cnt}, (32'd8 + i) % 16);
        end
        check("wrap_zero", {28'b0, retire_cnt}, 32'd0);

        // Asynchronous reset while waiting on memory
        alu_result = 32'h99;
        beat(2'b00, 4'd5, 1'b1, 4'hF, 4'hF);
        tick();
        beat(2'b01, 4'd10, 1'b1, 4'h0, 4'h0);
        tick();
        check("ar_ready0", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2 rf_RESET = 1'b0;
        #1;
        check("ar_wdata", rf_wdata, 32'd0);
        check("ar_flags", {28'b0, rf_flags}, 32'd0);
        check("ar_cnt", {28'b0, retire_cnt}, 32'd0);
        check("ar_waddr", {28'b0, rf_waddr}, 32'd0);
        check("ar_ready", {31'b0, in_ready}, 32'd1);
        #2 rf_RESET = 1'b1;
        dm_valid = 1'b1; dm_Q = 32'h1234;
        tick();
        check("late_we", {31'b0, rf_we}, 32'd0);
        check("late_cnt", {28'b0, retire_cnt}, 32'd0);
        check("late_ready", {31'b0, in_ready}, 32'd1);
        dm_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_pipe.md
# wb_pipe

Parametrised writeback stage with a handshake, sitting between the MEM stage and the register file / flag register of the processor. Each cycle it accepts at most one instruction. It selects the writeback value from the PC-link, data-memory, ALU or immediate source, and waits in a dedicated state when the memory data has not yet arrived. It then commits a registered register-file write, a masked flag update and a retire-count increment.

## Interface

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 4, register index width.
- N_FLAGS, 4, flag count; bit order is {O,S,C,Z} for the default of 4.
- CNT_W, 32, retire counter width.
- ZERO_REG, 1, when 1, writes to register 0 are suppressed.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- rf_RESET  in  1  reset, asynchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- wb_flush  in  1  discard the pending or incoming instruction.
- mxpc_out  in  DATA_W  PC-link value.
- dm_Q  in  DATA_W  data-memory read data.
- dm_valid  in  1  dm_Q is valid this cycle.
- alu_result  in  DATA_W  ALU result.
- imm  in  DATA_W  immediate value.
- uc_S_MXRB  in  2  source select: 00 alu_result, 01 dm_Q, 10 mxpc_out, 11 imm.
- uc_W_RD  in  1  register write enable.
- rd_addr  in  ADDR_W  destination register.
- alu_flags  in  N_FLAGS  new flag values.
- uc_W_RF  in  N_FLAGS  per-flag write mask.
- rf_we  out  1  one-cycle register write strobe.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- rf_flags  out  N_FLAGS  flag register.
- retire_cnt  out  CNT_W  committed-instruction count.

## Operation

- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
- Accept: in_valid & in_ready & !wb_flush at an edge.
- Accept in IDLE, uc_S_MXRB≠01 or dm_valid=1:
  - commit immediately with the selected source;
  - stay in IDLE.
- Accept in IDLE, uc_S_MXRB=01 and dm_valid=0:
  - capture uc_W_RD, rd_addr, alu_flags and uc_W_RF into holding registers;
  - go to WAIT_MEM.
- In WAIT_MEM, dm_valid=1 & !wb_flush:
  - commit with dm_Q and the held fields;
  - go to IDLE.
- In WAIT_MEM, wb_flush=1: go to IDLE with no commit. Flush wins over a simultaneous dm_valid.
- wb_flush in IDLE: the beat offered that cycle is dropped, not committed.
- Commit, registered on that edge:
  - rf_we = uc_W_RD & !(ZERO_REG & rd_addr==0);
  - rf_waddr, rf_wdata loaded;
  - for each i, rf_flags[i] takes alu_flags[i] where uc_W_RF[i]=1 and holds otherwise;
  - retire_cnt += 1 (wraps modulo 2^CNT_W). It counts suppressed or no-write commits too.
- No commit on an edge: rf_we=0; rf_waddr and rf_wdata hold their last values.
- Reset (rf_RESET low, asynchronous):
  - state=IDLE;
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_flags=0, retire_cnt=0, holding registers=0;
  - any pending WAIT_MEM is lost.
- Inputs are ignored while reset is held.

## Timing

- Latency: accept at edge k with a ready source → rf_we, rf_wdata and rf_flags visible after edge k, for exactly one cycle of rf_we.
- Memory wait: commit occurs on the first edge in WAIT_MEM with dm_valid=1. It is visible after that edge. in_ready returns to 1 in the following cycle.
- Throughput: one instruction per cycle while no memory wait occurs; back-to-back commits produce consecutive rf_we pulses.
- in_ready depends on state only (no combinational path from inputs).
- Reset deassertion: the first accept is possible at the first rising edge after rf_RESET goes high.

## Test plan

- Reset, then accept: alu_result=0x0000_00A5, uc_S_MXRB=00, rd_addr=3, uc_W_RD=1 → after one edge rf_we=1, rf_waddr=3, rf_wdata=0xA5, retire_cnt=1. Next cycle rf_we=0.
- Memory wait: uc_S_MXRB=01 with dm_valid=0 → in_ready=0 for 3 cycles. Then dm_valid=1 with dm_Q=0xDEAD_BEEF → single rf_we pulse with 0xDEADBEEF to the held rd_addr, and in_ready=1 after.
- Flag mask: rf_flags=0000, alu_flags=1111, uc_W_RF=0101 → rf_flags=0101. A following commit with alu_flags=0000, uc_W_RF=0001 → rf_flags=0100.
- Flush: in WAIT_MEM, assert wb_flush and dm_valid in the same cycle → no rf_we, retire_cnt unchanged, state IDLE.
- Suppression and wrap: with ZERO_REG=1, a commit to rd_addr=0 → rf_we=0 and retire_cnt increments. With CNT_W=4, 16 commits → retire_cnt wraps to 0.
- Reset mid-operation: assert rf_RESET low while in WAIT_MEM → all outputs go to 0 asynchronously. After release, in_ready=1, and a late dm_valid produces no write.
